// File: rtl/ibuf_wr_ctrl.sv
// ============================================================================
// Module      : ibuf_wr_ctrl
// Description : Takes the AXI read-data beats of the input-buffer bursts and
//               writes them into a row-banked line buffer of STRIDE+1 rows.
//               It holds each full block for the depthwise engine and flags
//               burst protocol errors. Optional macro IBUF_RRESP_CHK_EN also
//               treats a non-OKAY rresp as an error.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ibuf_wr_ctrl #(
    parameter int  DW     = 32,
    parameter int  BUFW   = 32,
    parameter int  BURST  = 16,
    parameter int  STRIDE = 2,
    localparam int c_nrow = STRIDE + 1,
    localparam int c_aw   = $clog2(BUFW)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DW-1:0]     rdata,
    input  logic              rvalid,
    input  logic              rlast,
    input  logic [1:0]        rresp,
    output logic              rready,
    output logic              buf_we,
    output logic [c_nrow-1:0] buf_wsel,
    output logic [c_aw-1:0]   buf_waddr,
    output logic [DW-1:0]     buf_wdata,
    output logic              row_done,
    output logic              blk_full,
    input  logic              blk_release,
    output logic              err
);

    localparam int c_bw = (BURST > 1) ? $clog2(BURST) : 1;
    localparam int c_rw = $clog2(c_nrow);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_FULL = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t          r_state;
    logic [c_bw-1:0] r_beat_cnt;
    logic [c_aw-1:0] r_word_cnt;
    logic [c_rw-1:0] r_row_cnt;

    logic w_acc;
    logic w_last_beat;
    logic w_rlast_err;
    logic w_rresp_err;
    logic w_bad;
    logic w_good;
    logic w_row_end;
    logic w_blk_end;

    // ERR keeps rready high so the interconnect can drain the broken burst.
    assign rready      = (r_state == S_FILL) || (r_state == S_ERR);
    assign w_acc       = rvalid && (r_state == S_FILL);
    assign w_last_beat = (r_beat_cnt == c_bw'(BURST - 1));
    assign w_rlast_err = w_acc && (rlast != w_last_beat);

`ifdef IBUF_RRESP_CHK_EN
    assign w_rresp_err = w_acc && (rresp != 2'b00);
`else
    logic [1:0] w_rresp_unused;
    assign w_rresp_unused = rresp;
    assign w_rresp_err    = 1'b0;
`endif

    assign w_bad     = w_rlast_err || w_rresp_err;
    assign w_good    = w_acc && !w_bad;
    assign w_row_end = (r_word_cnt == c_aw'(BUFW - 1));
    assign w_blk_end = w_row_end && (r_row_cnt == c_rw'(c_nrow - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_beat_cnt <= '0;
            r_word_cnt <= '0;
            r_row_cnt  <= '0;
            buf_we     <= 1'b0;
            buf_wsel   <= '0;
            buf_waddr  <= '0;
            buf_wdata  <= '0;
            row_done   <= 1'b0;
            blk_full   <= 1'b0;
            err        <= 1'b0;
        end else begin
            buf_we   <= w_good;
            row_done <= w_good && w_row_end;

            if (w_good) begin
                buf_wdata  <= rdata;
                buf_waddr  <= r_word_cnt;
                buf_wsel   <= c_nrow'(1) << r_row_cnt;
                r_beat_cnt <= w_last_beat ? '0 : r_beat_cnt + c_bw'(1);
                r_word_cnt <= w_row_end ? '0 : r_word_cnt + c_aw'(1);
                if (w_row_end) begin
                    r_row_cnt <= w_blk_end ? '0 : r_row_cnt + c_rw'(1);
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_FILL;
                        r_beat_cnt <= '0;
                        r_word_cnt <= '0;
                        r_row_cnt  <= '0;
                        err        <= 1'b0;
                    end
                end
                S_FILL: begin
                    if (w_bad) begin
                        r_state    <= S_ERR;
                        r_beat_cnt <= '0;
                        err        <= 1'b1;
                    end else if (w_good && w_blk_end) begin
                        r_state  <= S_FULL;
                        blk_full <= 1'b1;
                    end
                end
                S_FULL: begin
                    if (blk_release) begin
                        r_state  <= S_FILL;
                        blk_full <= 1'b0;
                    end
                end
                S_ERR: begin
                    blk_full <= 1'b0;
                    if (start) begin
                        r_state    <= S_FILL;
                        r_beat_cnt <= '0;
                        r_word_cnt <= '0;
                        r_row_cnt  <= '0;
                        err        <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ibuf_wr_ctrl.sv
// ============================================================================
// Module      : tb_ibuf_wr_ctrl
// Description : Randomized self-checking bench for ibuf_wr_ctrl against a
//               beat-count reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ibuf_wr_ctrl;

    localparam int DW     = 32;
    localparam int BUFW   = 32;
    localparam int BURST  = 16;
    localparam int STRIDE = 2;
    localparam int NROW   = STRIDE + 1;
    localparam int AW     = $clog2(BUFW);
    localparam int NBLK   = NROW * BUFW;

    localparam int M_IDLE = 0;
    localparam int M_FILL = 1;
    localparam int M_FULL = 2;
    localparam int M_ERR  = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [DW-1:0]   rdata;
    logic            rvalid;
    logic            rlast;
    logic [1:0]      rresp;
    logic            rready;
    logic            buf_we;
    logic [NROW-1:0] buf_wsel;
    logic [AW-1:0]   buf_waddr;
    logic [DW-1:0]   buf_wdata;
    logic            row_done;
    logic            blk_full;
    logic            blk_release;
    logic            err;

    ibuf_wr_ctrl #(
        .DW     (DW),
        .BUFW   (BUFW),
        .BURST  (BURST),
        .STRIDE (STRIDE)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .rdata       (rdata),
        .rvalid      (rvalid),
        .rlast       (rlast),
        .rresp       (rresp),
        .rready      (rready),
        .buf_we      (buf_we),
        .buf_wsel    (buf_wsel),
        .buf_waddr   (buf_waddr),
        .buf_wdata   (buf_wdata),
        .row_done    (row_done),
        .blk_full    (blk_full),
        .blk_release (blk_release),
        .err         (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_wr     = 0;

    // Reference model: m_k counts beats accepted into the current block.
    int          m_mode;
    int          m_k;
    bit          e_we, e_rd, e_full, e_err;
    logic [63:0] e_wsel, e_waddr, e_wdata;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic bit exp_last();
        return (m_k % BURST) == BURST - 1;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE;
        m_k    = 0;
        e_we   = 0;
        e_rd   = 0;
        e_full = 0;
        e_err  = 0;
    endtask

    // Applies one cycle of inputs, advances the model, then checks at the next negedge.
    task automatic cycle(input bit v, input logic [DW-1:0] d, input bit l,
                         input logic [1:0] rs, input bit st, input bit rel);
        bit bad;
        rvalid = v; rdata = d; rlast = l; rresp = rs; start = st; blk_release = rel;
        e_we = 0;
        e_rd = 0;
        case (m_mode)
            M_IDLE: if (st) begin m_mode = M_FILL; m_k = 0; end
            M_FILL: if (v) begin
                bad = (l != exp_last());
`ifdef IBUF_RRESP_CHK_EN
                if (rs != 2'b00) bad = 1;
`endif
                if (bad) begin
                    m_mode = M_ERR;
                    e_err  = 1;
                end else begin
                    e_we    = 1;
                    e_wsel  = 64'(1) << (m_k / BUFW);
                    e_waddr = 64'(m_k % BUFW);
                    e_wdata = 64'(d);
                    e_rd    = (m_k % BUFW) == BUFW - 1;
                    m_k++;
                    if (m_k == NBLK) begin
                        m_k    = 0;
                        m_mode = M_FULL;
                        e_full = 1;
                    end
                end
            end
            M_FULL: if (rel) begin m_mode = M_FILL; e_full = 0; end
            default: if (st) begin m_mode = M_FILL; m_k = 0; e_err = 0; end
        endcase
        @(negedge clk);
        if (buf_we) n_wr++;
        check_eq("rready", 64'(rready), 64'(m_mode == M_FILL || m_mode == M_ERR));
        check_eq("buf_we", 64'(buf_we), 64'(e_we));
        check_eq("row_done", 64'(row_done), 64'(e_rd));
        check_eq("blk_full", 64'(blk_full), 64'(e_full));
        check_eq("err", 64'(err), 64'(e_err));
        if (e_we) begin
            check_eq("buf_wsel", 64'(buf_wsel), e_wsel);
            check_eq("buf_waddr", 64'(buf_waddr), e_waddr);
            check_eq("buf_wdata", 64'(buf_wdata), e_wdata);
        end
    endtask

    task automatic beat(input logic [DW-1:0] d);
        cycle(1, d, exp_last(), 2'b00, 0, 0);
    endtask

    task automatic idle(input bit rel);
        cycle(0, '0, 0, 2'b00, 0, rel);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_rready"}, 64'(rready), 64'(0));
        check_eq({tag, "_buf_we"}, 64'(buf_we), 64'(0));
        check_eq({tag, "_buf_wsel"}, 64'(buf_wsel), 64'(0));
        check_eq({tag, "_buf_waddr"}, 64'(buf_waddr), 64'(0));
        check_eq({tag, "_buf_wdata"}, 64'(buf_wdata), 64'(0));
        check_eq({tag, "_row_done"}, 64'(row_done), 64'(0));
        check_eq({tag, "_blk_full"}, 64'(blk_full), 64'(0));
        check_eq({tag, "_err"}, 64'(err), 64'(0));
    endtask

    initial begin
        rst_n = 0; start = 0; rdata = '0; rvalid = 1; rlast = 0; rresp = 2'b00; blk_release = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1;
        cycle(1, 32'hdead, 0, 2'b00, 0, 0);
        cycle(1, 32'hbeef, 1, 2'b00, 0, 0);

        // Full block of back-to-back beats, rdata = beat index.
        cycle(0, '0, 0, 2'b00, 1, 0);
        n_wr = 0;
        for (int i = 0; i < NBLK; i++) beat(DW'(i));
        check_eq("blk_writes", 64'(n_wr), 64'(NBLK));

        // Held in FULL: offered beats must not be written.
        n_wr = 0;
        repeat (10) cycle(1, 32'h55, 0, 2'b00, 0, 0);
        check_eq("full_writes", 64'(n_wr), 64'(0));
        idle(1);
        beat(32'h1234);

        // Random gaps between beats.
        for (int i = 1; i < NBLK; i++) begin
            repeat ($urandom_range(0, 3)) idle(0);
            beat($urandom);
        end
        idle(0);
        idle(1);

        // Early rlast on beat 7, drain in ERR, recover with start.
        for (int i = 0; i < 7; i++) beat(DW'(100 + i));
        cycle(1, 32'h107, 1, 2'b00, 0, 0);
        repeat (5) cycle(1, $urandom, 1'($urandom), 2'b00, 0, 0);
        cycle(0, '0, 0, 2'b00, 1, 0);

        // Error response on beat 5.
        for (int i = 0; i < BURST; i++)
            cycle(1, DW'(200 + i), exp_last(), (i == 5) ? 2'b10 : 2'b00, 0, 0);
        cycle(0, '0, 0, 2'b00, 1, 0);

        // Asynchronous reset mid-burst.
        for (int i = 0; i < 3; i++) beat(DW'(300 + i));
        rvalid = 0;
        #2 rst_n = 0;
        #1 check_reset_outputs("async_rst");
        model_reset();
        @(negedge clk);
        rst_n = 1;
        idle(0);

        // Randomized traffic with occasional protocol faults.
        for (int i = 0; i < 3000; i++)
            cycle($urandom_range(0, 3) != 0, $urandom,
                  exp_last() ^ ($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 99) == 0) ? 2'b10 : 2'b00,
                  $urandom_range(0, 79) == 0, $urandom_range(0, 5) == 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
